// File: rtl/fifo_tree_ctrl.sv
// Sequencing controller for the WalkSAT clause FIFO tree: loads one batch of
// candidates, drains up to MAX_PICKS to the pick stage, and recovers from overflow.
module fifo_tree_ctrl #(
  parameter int CLAUSE_COUNT  = 20,
  parameter int CLAUSE_WIDTH  = 9,
  parameter int MAX_PICKS     = 12,
  parameter int SETTLE_CYCLES = 4,
  parameter int CNT_W         = $clog2(CLAUSE_COUNT + 1)
) (
  input  logic                                 clk_i,
  input  logic                                 rst_ni,
  input  logic                                 batch_valid_i,
  output logic                                 batch_ready_o,
  input  logic [CLAUSE_COUNT*CLAUSE_WIDTH-1:0] clauses_i,
  input  logic [CLAUSE_COUNT-1:0]              clauses_valid_i,
  output logic [CLAUSE_COUNT*CLAUSE_WIDTH-1:0] tree_clauses_o,
  output logic [CLAUSE_COUNT-1:0]              tree_valid_o,
  output logic                                 tree_wr_en_o,
  output logic                                 tree_rd_en_o,
  output logic                                 tree_cof_o,
  input  logic                                 tree_empty_i,
  input  logic                                 tree_of_i,
  input  logic [CLAUSE_WIDTH-1:0]              tree_clause_i,
  output logic                                 clause_valid_o,
  input  logic                                 clause_ready_i,
  output logic [CLAUSE_WIDTH-1:0]              clause_o,
  output logic                                 batch_done_o,
  output logic [CNT_W-1:0]                     done_count_o,
  output logic                                 done_of_o
);

  localparam int SW = $clog2(SETTLE_CYCLES + 1);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_DRAIN, S_FLUSH, S_DONE} state_t;

  state_t                            r_state, w_state_next;
  logic                              r_started;
  logic [CLAUSE_COUNT*CLAUSE_WIDTH-1:0] r_clauses;
  logic [CLAUSE_COUNT-1:0]           r_valid;
  logic [CNT_W-1:0]                  r_pending, w_pending_next;
  logic [CNT_W-1:0]                  r_delivered, w_delivered_next;
  logic                              r_of_seen, w_of_seen_next;
  logic                              r_flush_of, w_flush_of_next;
  logic                              r_cof, w_cof_next;
  logic [SW-1:0]                     r_settle, w_settle_next;
  logic [CNT_W-1:0]                  w_popcnt;
  logic                              w_accept;
  logic                              w_pop;

  always_comb begin
    w_popcnt = '0;
    for (int j = 0; j < CLAUSE_COUNT; j++) begin
      w_popcnt = w_popcnt + CNT_W'(clauses_valid_i[j]);
    end
  end

  // r_started keeps batch_ready_o low until the first edge after reset release
  assign w_accept = (r_state == S_IDLE) && r_started && batch_valid_i;
  assign clause_o = tree_clause_i;
  assign tree_clauses_o = r_clauses;
  assign tree_valid_o   = r_valid;

  always_comb begin
    w_state_next     = r_state;
    w_pending_next   = r_pending;
    w_delivered_next = r_delivered;
    w_of_seen_next   = r_of_seen;
    w_flush_of_next  = r_flush_of;
    w_cof_next       = 1'b0;
    w_settle_next    = r_settle;
    w_pop            = 1'b0;
    batch_ready_o    = 1'b0;
    tree_wr_en_o     = 1'b0;
    tree_rd_en_o     = 1'b0;
    tree_cof_o       = 1'b0;
    clause_valid_o   = 1'b0;
    batch_done_o     = 1'b0;
    done_count_o     = '0;
    done_of_o        = 1'b0;
    case (r_state)
      S_IDLE: begin
        batch_ready_o = r_started;
        if (w_accept) begin
          w_pending_next   = w_popcnt;
          w_delivered_next = '0;
          w_of_seen_next   = 1'b0;
          w_flush_of_next  = 1'b0;
          w_settle_next    = '0;
          w_state_next     = (w_popcnt == '0) ? S_DONE : S_LOAD;
        end
      end
      S_LOAD: begin
        tree_wr_en_o = 1'b1;
        w_state_next = S_DRAIN;
      end
      S_DRAIN: begin
        clause_valid_o = !tree_empty_i;
        w_pop          = clause_valid_o && clause_ready_i;
        tree_rd_en_o   = w_pop;
        if (w_pop) begin
          if (r_delivered < CNT_W'(MAX_PICKS)) w_delivered_next = r_delivered + 1'b1;
          if (r_pending != '0) w_pending_next = r_pending - 1'b1;
        end
        if (tree_of_i) begin
          w_of_seen_next  = 1'b1;
          w_flush_of_next = 1'b1;
          w_cof_next      = 1'b1;
          w_settle_next   = '0;
          w_state_next    = S_FLUSH;
        end else if (w_pending_next == '0) begin
          w_state_next = S_DONE;
        end else if (w_delivered_next == CNT_W'(MAX_PICKS)) begin
          w_flush_of_next = 1'b0;
          w_state_next    = S_FLUSH;
        end
      end
      S_FLUSH: begin
        w_pop        = !tree_empty_i;
        tree_rd_en_o = w_pop;
        tree_cof_o   = r_cof;
        if (w_pop && (r_pending != '0)) w_pending_next = r_pending - 1'b1;
        if (tree_of_i) begin
          // a flag still high during the clear pulse is the one being cleared
          w_of_seen_next  = 1'b1;
          w_flush_of_next = 1'b1;
          w_cof_next      = !r_cof;
          w_settle_next   = '0;
        end else if (r_flush_of) begin
          w_settle_next = tree_empty_i ? r_settle + 1'b1 : '0;
          if (w_settle_next == SW'(SETTLE_CYCLES)) w_state_next = S_DONE;
        end else if (w_pending_next == '0) begin
          w_state_next = S_DONE;
        end
      end
      S_DONE: begin
        batch_done_o = 1'b1;
        done_count_o = r_delivered;
        done_of_o    = r_of_seen;
        w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state     <= S_IDLE;
      r_started   <= 1'b0;
      r_clauses   <= '0;
      r_valid     <= '0;
      r_pending   <= '0;
      r_delivered <= '0;
      r_of_seen   <= 1'b0;
      r_flush_of  <= 1'b0;
      r_cof       <= 1'b0;
      r_settle    <= '0;
    end else begin
      r_state     <= w_state_next;
      r_started   <= 1'b1;
      r_pending   <= w_pending_next;
      r_delivered <= w_delivered_next;
      r_of_seen   <= w_of_seen_next;
      r_flush_of  <= w_flush_of_next;
      r_cof       <= w_cof_next;
      r_settle    <= w_settle_next;
      if (w_accept) begin
        r_clauses <= clauses_i;
        r_valid   <= clauses_valid_i;
      end
    end
  end

endmodule

// File: tb/tb_fifo_tree_ctrl.sv
// Bench for fifo_tree_ctrl: register-based clause tree model plus a scoreboard
// of expected clause IDs filled at batch drive time and consumed on each transfer.
module tb_fifo_tree_ctrl;
  localparam int CC    = 20;
  localparam int CW    = 9;
  localparam int MP    = 12;
  localparam int SC    = 4;
  localparam int CNT_W = $clog2(CC + 1);

  logic              clk_i, rst_ni;
  logic              batch_valid_i, batch_ready_o;
  logic [CC*CW-1:0]  clauses_i, tree_clauses_o;
  logic [CC-1:0]     clauses_valid_i, tree_valid_o;
  logic              tree_wr_en_o, tree_rd_en_o, tree_cof_o;
  logic              tree_empty_i, tree_of_i;
  logic [CW-1:0]     tree_clause_i, clause_o;
  logic              clause_valid_o, clause_ready_i;
  logic              batch_done_o, done_of_o;
  logic [CNT_W-1:0]  done_count_o;

  fifo_tree_ctrl #(.CLAUSE_COUNT(CC), .CLAUSE_WIDTH(CW), .MAX_PICKS(MP),
                   .SETTLE_CYCLES(SC)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .batch_valid_i(batch_valid_i), .batch_ready_o(batch_ready_o),
    .clauses_i(clauses_i), .clauses_valid_i(clauses_valid_i),
    .tree_clauses_o(tree_clauses_o), .tree_valid_o(tree_valid_o),
    .tree_wr_en_o(tree_wr_en_o), .tree_rd_en_o(tree_rd_en_o), .tree_cof_o(tree_cof_o),
    .tree_empty_i(tree_empty_i), .tree_of_i(tree_of_i), .tree_clause_i(tree_clause_i),
    .clause_valid_o(clause_valid_o), .clause_ready_i(clause_ready_i), .clause_o(clause_o),
    .batch_done_o(batch_done_o), .done_count_o(done_count_o), .done_of_o(done_of_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // tree model: show-ahead FIFO, one-cycle write latency, overflow flag on request
  logic [CW-1:0] mem [0:63];
  logic [5:0]    rd_ptr, wr_ptr;
  logic [6:0]    cnt;
  logic          of_req, r_of;
  int            npush;

  assign tree_empty_i  = (cnt == 0);
  assign tree_clause_i = tree_empty_i ? '0 : mem[rd_ptr];
  assign tree_of_i     = r_of;

  always @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_ptr <= '0; wr_ptr <= '0; cnt <= '0; r_of <= 1'b0;
    end else begin
      npush = 0;
      if (tree_wr_en_o) begin
        for (int j = 0; j < CC; j++) begin
          if (tree_valid_o[j]) begin
            mem[6'(int'(wr_ptr) + npush)] <= tree_clauses_o[j*CW +: CW];
            npush++;
          end
        end
      end
      wr_ptr <= 6'(int'(wr_ptr) + npush);
      if (tree_rd_en_o && cnt != 0) begin
        rd_ptr <= rd_ptr + 1'b1;
        cnt    <= 7'(int'(cnt) + npush - 1);
      end else begin
        cnt    <= 7'(int'(cnt) + npush);
      end
      if (of_req) r_of <= 1'b1;
      else if (tree_cof_o) r_of <= 1'b0;
    end
  end

  int checks = 0;
  int failures = 0;
  logic [CW-1:0] exp_q [$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // mode 0: ready high; 1: ready pattern 1,0,0,1; 2: overflow after 2 deliveries
  task automatic run_batch(input logic [CC-1:0] mask, input int base, input int mode,
                           input int abort_at, input int exp_count, input logic exp_of,
                           input int exp_left);
    int k, done_k, delivered, wr_seen, cof_cnt, empty_run, vmax, idx, of_sent;
    logic done, prev_stall, found;
    logic [CW-1:0] prev_id, id;
    delivered = 0; wr_seen = 0; cof_cnt = 0; empty_run = 0; vmax = 0; of_sent = 0;
    done = 1'b0; done_k = 0; prev_stall = 1'b0; prev_id = '0;
    k = 0;
    while (!batch_ready_o && k < 50) begin
      @(posedge clk_i); #1; k++;
    end
    check("ready_before", 32'(batch_ready_o), 1);
    for (int j = 0; j < CC; j++) begin
      id = CW'((base + j * 13) % 512);
      clauses_i[j*CW +: CW] = id;
      if (mask[j]) exp_q.push_back(id);
    end
    clauses_valid_i = mask;
    batch_valid_i   = 1'b1;
    @(posedge clk_i); #1;
    batch_valid_i = 1'b0;
    for (k = 1; k < 200 && !done; k++) begin
      of_req = 1'b0;
      case (mode)
        1: begin idx = (k - 1) % 4; clause_ready_i = (idx == 0 || idx == 3); end
        2: begin
          clause_ready_i = (delivered < 2);
          if (delivered == 2 && of_sent == 0) begin of_req = 1'b1; of_sent = 1; end
        end
        default: clause_ready_i = 1'b1;
      endcase
      #1;
      if (k == 1) check("wr_en_t1", 32'(tree_wr_en_o), 32'(mask != 0));
      if (tree_wr_en_o) wr_seen++;
      if (tree_cof_o) cof_cnt++;
      if (delivered >= MP && clause_valid_o) vmax++;
      if (prev_stall && clause_valid_o) check("stall_hold", 32'(clause_o), 32'(prev_id));
      prev_stall = clause_valid_o && !clause_ready_i;
      prev_id    = clause_o;
      if (clause_valid_o && clause_ready_i) begin
        found = 1'b0;
        for (int i = 0; i < exp_q.size(); i++) begin
          if (!found && exp_q[i] == clause_o) begin
            exp_q.delete(i);
            found = 1'b1;
          end
        end
        check("xfer_match", 32'(found), 1);
        delivered++;
      end
      if (batch_done_o) begin
        done = 1'b1;
        done_k = k;
        check("done_count", 32'(done_count_o), 32'(exp_count));
        check("done_of", 32'(done_of_o), 32'(exp_of));
        check("sb_left", 32'(exp_q.size()), 32'(exp_left));
        check("tree_empty_at_done", 32'(tree_empty_i), 1);
        if (mode == 2) begin
          check("cof_pulses", 32'(cof_cnt), 1);
          check("settle_cycles", 32'(empty_run), SC);
        end
        if (exp_count == MP) check("valid_after_max", 32'(vmax), 0);
      end
      empty_run = tree_empty_i ? empty_run + 1 : 0;
      if (abort_at != 0 && delivered == abort_at) break;
      if (!done) begin
        @(posedge clk_i); #1;
      end
    end
    clause_ready_i = 1'b0;
    of_req = 1'b0;
    if (abort_at != 0) begin
      $display("batch mask=%05h aborted after %0d deliveries", mask, delivered);
      return;
    end
    if (!done) check("done_timeout", 0, 1);
    if (mask == 0) begin
      check("empty_done_latency", 32'(done_k), 1);
      check("empty_no_wr", 32'(wr_seen), 0);
    end
    @(posedge clk_i); #1;
    check("ready_after_done", 32'(batch_ready_o), 1);
    check("done_pulse_1cyc", 32'(batch_done_o), 0);
    $display("batch mask=%05h delivered=%0d done_count=%0d done_of=%0b cycles=%0d",
             mask, delivered, done_count_o, exp_of, done_k);
    exp_q.delete();
  endtask

  task automatic check_all_low(input string tag);
    check({tag, "_ready"}, 32'(batch_ready_o), 0);
    check({tag, "_outs"}, 32'({clause_valid_o, tree_wr_en_o, tree_rd_en_o, tree_cof_o,
                                batch_done_o, done_of_o}), 0);
    check({tag, "_count"}, 32'(done_count_o), 0);
    check({tag, "_tree_data"}, 32'((|tree_clauses_o) | (|tree_valid_o)), 0);
    check({tag, "_clause"}, 32'(clause_o), 0);
  endtask

  initial begin
    rst_ni = 1'b0; batch_valid_i = 1'b0; clauses_i = '0; clauses_valid_i = '0;
    clause_ready_i = 1'b0; of_req = 1'b0;
    #1;
    check_all_low("reset");
    repeat (3) @(posedge clk_i);
    #2 rst_ni = 1'b1;
    #1 check("ready_pre_edge", 32'(batch_ready_o), 0);
    @(posedge clk_i); #1;
    check("ready_post_edge", 32'(batch_ready_o), 1);

    run_batch(20'h00013, 5,   0, 0, 3,  1'b0, 0);
    run_batch(20'h00000, 40,  0, 0, 0,  1'b0, 0);
    run_batch(20'hFFFFF, 100, 0, 0, MP, 1'b0, CC - MP);
    run_batch(20'h84211, 200, 1, 0, 5,  1'b0, 0);
    run_batch(20'h0F100, 300, 2, 0, 2,  1'b1, 3);

    run_batch(20'h0001F, 400, 0, 1, 0, 1'b0, 0);
    #2 rst_ni = 1'b0;
    #1 check_all_low("mid_reset");
    exp_q.delete();
    @(posedge clk_i); @(posedge clk_i);
    #2 rst_ni = 1'b1;
    @(posedge clk_i); #1;
    check("ready_after_rst", 32'(batch_ready_o), 1);
    run_batch(20'h00700, 450, 0, 0, 3, 1'b0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "timeout");
  end
endmodule
